// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for multicycle_alu: ALU-control OP encoding and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  function automatic logic is_mul_div(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multicycle_alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// hi_o (upper product / remainder) is a port only when ALU_HILO_EN is defined.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             mode_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ALU_HILO_EN
  output logic [WIDTH-1:0] hi_o,
`endif
  output logic [WIDTH-1:0] lo_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, div_q;
  logic [WIDTH:0]   sum, shifted;

  // lo/hi outputs are the result of the step in progress, so the final
  // iteration's value is available to the caller on the same edge.
  always_comb begin
    sum     = '0;
    shifted = '0;
    hi_step = hi_q;
    lo_step = lo_q;
    if (div_q) begin
      shifted = {hi_q, lo_q[WIDTH-1]};
      if (shifted >= {1'b0, opnd_q}) begin
        hi_step = shifted[WIDTH-1:0] - opnd_q;
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = shifted[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign lo_o   = lo_step;
`ifdef ALU_HILO_EN
  assign hi_o   = hi_step;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      hi_q   <= '0;
      lo_q   <= mode_div_i ? a_i : b_i;
      opnd_q <= mode_div_i ? b_i : a_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      div_q  <= mode_div_i;
    end else if (busy_q) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle add/sub/and/or/slt, iterative mul/div via seq_muldiv.
// Define ALU_HILO_EN to expose HI (upper product / remainder).
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
`ifdef ALU_HILO_EN
  output logic [WIDTH-1:0] HI,
`endif
  output logic             DIV0
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             div0_q, div0_d;
`ifdef ALU_HILO_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] eng_hi;
`endif
  logic [WIDTH-1:0] eng_lo, alu_res;
  logic             eng_done, accept, b_zero, go_long;

  assign accept  = START && (state_q != S_RUN);
  assign b_zero  = (B == '0);
  // Divide-by-zero bypasses the engine and completes like a single-cycle op.
  assign go_long = accept && is_mul_div(OP) && !((OP == OP_DIV) && b_zero);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .load_i     (go_long),
    .mode_div_i (OP == OP_DIV),
    .a_i        (A),
    .b_i        (B),
`ifdef ALU_HILO_EN
    .hi_o       (eng_hi),
`endif
    .lo_o       (eng_lo),
    .done_o     (eng_done)
  );

  always_comb begin
    case (OP)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    div0_d   = div0_q;
`ifdef ALU_HILO_EN
    hi_d     = hi_q;
`endif
    case (state_q)
      S_RUN: if (eng_done) state_d = S_FIN;
      default: begin
        if (!accept)      state_d = S_IDLE;
        else if (go_long) state_d = S_RUN;
        else              state_d = S_FIN;
      end
    endcase

    if (accept && !go_long) begin
      if (OP == OP_NOP) begin
        div0_d = 1'b0;
      end else if (OP == OP_DIV) begin
        result_d = '1;
        zero_d   = 1'b0;
        div0_d   = 1'b1;
`ifdef ALU_HILO_EN
        hi_d     = A;
`endif
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        div0_d   = 1'b0;
      end
    end else if (eng_done) begin
      result_d = eng_lo;
      zero_d   = (eng_lo == '0);
      div0_d   = 1'b0;
`ifdef ALU_HILO_EN
      hi_d     = eng_hi;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      div0_q   <= 1'b0;
`ifdef ALU_HILO_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      div0_q   <= div0_d;
`ifdef ALU_HILO_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;
  assign DIV0   = div0_q;
  assign BUSY   = (state_q == S_RUN);
  assign DONE   = (state_q == S_FIN);
`ifdef ALU_HILO_EN
  assign HI     = hi_q;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32); HI checks need ALU_HILO_EN.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [2:0]   OP = OP_NOP;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] RESULT;
  logic         ZERO, BUSY, DONE, DIV0;
`ifdef ALU_HILO_EN
  logic [W-1:0] HI;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .OP     (OP),
    .A      (A),
    .B      (B),
    .RESULT (RESULT),
    .ZERO   (ZERO),
    .BUSY   (BUSY),
    .DONE   (DONE),
`ifdef ALU_HILO_EN
    .HI     (HI),
`endif
    .DIV0   (DIV0)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request at a falling edge; returns in the cycle after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    START = 1'b1;
    OP = op;
    A = a;
    B = b;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic run_long(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc, output int busy_cnt);
    issue(op, a, b);
    cyc = 1;
    busy_cnt = 0;
    while (DONE !== 1'b1 && cyc < 100) begin
      if (BUSY === 1'b1) busy_cnt++;
      @(negedge CLK);
      cyc++;
    end
  endtask

  int cyc, busy_cnt, dones;

  initial begin
    repeat (2) @(negedge CLK);
    check_eq("rst_result", 64'(RESULT), 64'd0);
    check_eq("rst_zero", 64'(ZERO), 64'd1);
    check_eq("rst_busy", 64'(BUSY), 64'd0);
    check_eq("rst_done", 64'(DONE), 64'd0);
    check_eq("rst_div0", 64'(DIV0), 64'd0);
    RST_N = 1'b1;

    issue(OP_ADD, 32'd7, 32'd5);
    check_eq("add_done", 64'(DONE), 64'd1);
    check_eq("add_busy", 64'(BUSY), 64'd0);
    check_eq("add_res", 64'(RESULT), 64'd12);
    check_eq("add_zero", 64'(ZERO), 64'd0);
    @(negedge CLK);
    check_eq("add_done_pulse", 64'(DONE), 64'd0);
    check_eq("add_res_hold", 64'(RESULT), 64'd12);

    issue(OP_SUB, 32'd3, 32'd3);
    check_eq("sub_res", 64'(RESULT), 64'd0);
    check_eq("sub_zero", 64'(ZERO), 64'd1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    check_eq("slt_neg", 64'(RESULT), 64'd1);
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    check_eq("slt_pos", 64'(RESULT), 64'd0);
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    check_eq("slt_extreme", 64'(RESULT), 64'd0);
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    check_eq("and_res", 64'(RESULT), 64'h0000_F000);
    issue(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
    check_eq("or_res", 64'(RESULT), 64'h0000_FFF0);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    check_eq("add_wrap", 64'(RESULT), 64'd0);
    check_eq("add_wrap_zero", 64'(ZERO), 64'd1);

    run_long(OP_MUL, 32'h0001_0000, 32'h0001_0000, cyc, busy_cnt);
    check_eq("mul_lat", 64'(cyc), 64'd33);
    check_eq("mul_busy", 64'(busy_cnt), 64'd32);
    check_eq("mul_res", 64'(RESULT), 64'd0);
    check_eq("mul_zero", 64'(ZERO), 64'd1);
`ifdef ALU_HILO_EN
    check_eq("mul_hi", 64'(HI), 64'd1);
`endif

    run_long(OP_MUL, 32'd12345, 32'd678, cyc, busy_cnt);
    check_eq("mul2_res", 64'(RESULT), 64'd8369910);

    run_long(OP_DIV, 32'd100, 32'd7, cyc, busy_cnt);
    check_eq("div_lat", 64'(cyc), 64'd33);
    check_eq("div_res", 64'(RESULT), 64'd14);
    check_eq("div_div0", 64'(DIV0), 64'd0);
`ifdef ALU_HILO_EN
    check_eq("div_hi", 64'(HI), 64'd2);
`endif

    run_long(OP_DIV, 32'hFFFF_FFFF, 32'h0001_0000, cyc, busy_cnt);
    check_eq("div_big", 64'(RESULT), 64'h0000_FFFF);
`ifdef ALU_HILO_EN
    check_eq("div_big_hi", 64'(HI), 64'h0000_FFFF);
`endif

    issue(OP_DIV, 32'd9, 32'd0);
    check_eq("div0_done", 64'(DONE), 64'd1);
    check_eq("div0_res", 64'(RESULT), 64'hFFFF_FFFF);
    check_eq("div0_flag", 64'(DIV0), 64'd1);
    check_eq("div0_zero", 64'(ZERO), 64'd0);
`ifdef ALU_HILO_EN
    check_eq("div0_hi", 64'(HI), 64'd9);
`endif

    issue(OP_NOP, 32'd1, 32'd1);
    check_eq("nop_done", 64'(DONE), 64'd1);
    check_eq("nop_res", 64'(RESULT), 64'hFFFF_FFFF);
    check_eq("nop_div0", 64'(DIV0), 64'd0);

    // START during RUN is dropped, and operand changes after acceptance are ignored.
    issue(OP_MUL, 32'd6, 32'd7);
    cyc = 1;
    dones = 0;
    while (DONE !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        START = 1'b1; OP = OP_ADD; A = 32'd1; B = 32'd1;
      end else begin
        START = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
      end
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    check_eq("ign_lat", 64'(cyc), 64'd33);
    check_eq("ign_res", 64'(RESULT), 64'd42);
    repeat (3) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check_eq("ign_no_extra_done", 64'(dones), 64'd0);

    // Back-to-back: a new request issued in the DONE cycle is accepted.
    issue(OP_ADD, 32'd2, 32'd3);
    check_eq("b2b_first", 64'(RESULT), 64'd5);
    START = 1'b1; OP = OP_SUB; A = 32'd10; B = 32'd4;
    @(negedge CLK);
    START = 1'b0;
    check_eq("b2b_done", 64'(DONE), 64'd1);
    check_eq("b2b_second", 64'(RESULT), 64'd6);

    // Asynchronous reset mid-multiply abandons the operation.
    issue(OP_MUL, 32'd3, 32'd5);
    repeat (9) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_eq("arst_busy", 64'(BUSY), 64'd0);
    check_eq("arst_done", 64'(DONE), 64'd0);
    check_eq("arst_res", 64'(RESULT), 64'd0);
    check_eq("arst_zero", 64'(ZERO), 64'd1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check_eq("arst_no_done", 64'(dones), 64'd0);
    issue(OP_ADD, 32'd1, 32'd1);
    check_eq("post_rst_done", 64'(DONE), 64'd1);
    check_eq("post_rst_res", 64'(RESULT), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
